// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence family (transmitter and detectors).
package seq_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2,
    S_GAP   = 2'd3
  } seq_state_t;

  localparam int GAP_MAX = 15;
  localparam int GAP_CW  = 4;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/seq_gen_tx_if.sv
// Start/ready request channel and serial output bundle of seq_gen_tx.
interface seq_gen_tx_if #(
  parameter int PAT_W = 8,
  parameter int REP_W = 4
);
  logic [PAT_W-1:0] pat_in;
  logic [REP_W-1:0] rep_in;
  logic             start;
  logic             abort;
  logic             ready;
  logic             xout;
  logic             xvalid;
  logic             frame_end;
  logic             done;

  modport master (
    output pat_in, rep_in, start, abort,
    input  ready, xout, xvalid, frame_end, done
  );
  modport slave (
    input  pat_in, rep_in, start, abort,
    output ready, xout, xvalid, frame_end, done
  );
endinterface

// File: rtl/seq_bit_counter.sv
// Loadable down-counter with a zero flag; load wins over decrement.
module seq_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/seq_gen_tx.sv
// Serial pattern transmitter: MSB-first, repeated with an idle gap.
// Define SEQ_GEN_TX_PARITY_EN to append an even-parity bit to every repetition.
module seq_gen_tx
  import seq_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int REP_W = 4,
  parameter int GAP   = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  seq_gen_tx_if.slave   bus
);
  localparam int                BW     = cnt_w(PAT_W);
  localparam logic [BW-1:0]     BIT_LD = BW'(PAT_W-1);
  localparam logic [GAP_CW-1:0] GAP_LD = (GAP > 0) ? GAP_CW'(GAP-1) : '0;

  seq_state_t       state_q, state_d;
  logic [PAT_W-1:0] pat_q, sr_q;
  logic             done_q, done_d;
  logic             ld_start, reload, shift_en, end_rep, gap_ld, gap_dec;
  logic             bit_zero, gap_zero, rep_zero;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      pat_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (ld_start) begin
        pat_q <= bus.pat_in;
        sr_q  <= bus.pat_in;
      end else if (reload)   sr_q <= pat_q;
      else if (shift_en)     sr_q <= {sr_q[PAT_W-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    ld_start = 1'b0;
    reload   = 1'b0;
    shift_en = 1'b0;
    end_rep  = 1'b0;
    gap_ld   = 1'b0;
    gap_dec  = 1'b0;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:
          if (bus.start) begin
            ld_start = 1'b1;
            state_d  = S_SHIFT;
          end
        S_SHIFT: begin
          shift_en = 1'b1;
          if (bit_zero) begin
`ifdef SEQ_GEN_TX_PARITY_EN
            state_d = S_PAR;
`else
            end_rep = 1'b1;
`endif
          end
        end
`ifdef SEQ_GEN_TX_PARITY_EN
        S_PAR: end_rep = 1'b1;
`endif
        S_GAP:
          if (gap_zero) begin
            reload  = 1'b1;
            state_d = S_SHIFT;
          end else begin
            gap_dec = 1'b1;
          end
        default: state_d = S_IDLE;
      endcase
      // The final repetition skips the gap and lands in IDLE with done.
      if (end_rep) begin
        if (rep_zero) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (GAP > 0) begin
          state_d = S_GAP;
          gap_ld  = 1'b1;
        end else begin
          state_d = S_SHIFT;
          reload  = 1'b1;
        end
      end
    end
  end

  seq_bit_counter #(.W(BW)) u_bit_cnt (
    .clk(clk), .reset_n(reset_n), .load(ld_start | reload),
    .dec(shift_en & ~bit_zero), .load_val(BIT_LD), .zero(bit_zero)
  );

  seq_bit_counter #(.W(GAP_CW)) u_gap_cnt (
    .clk(clk), .reset_n(reset_n), .load(gap_ld),
    .dec(gap_dec), .load_val(GAP_LD), .zero(gap_zero)
  );

  seq_bit_counter #(.W(REP_W)) u_rep_cnt (
    .clk(clk), .reset_n(reset_n), .load(ld_start),
    .dec(reload), .load_val(bus.rep_in), .zero(rep_zero)
  );

  assign bus.ready = (state_q == S_IDLE);
  assign bus.done  = done_q;
`ifdef SEQ_GEN_TX_PARITY_EN
  assign bus.xvalid    = (state_q == S_SHIFT) || (state_q == S_PAR);
  assign bus.xout      = (state_q == S_SHIFT) ? sr_q[PAT_W-1] :
                         (state_q == S_PAR)   ? ^pat_q : 1'b0;
  assign bus.frame_end = (state_q == S_PAR);
`else
  assign bus.xvalid    = (state_q == S_SHIFT);
  assign bus.xout      = bus.xvalid & sr_q[PAT_W-1];
  assign bus.frame_end = bus.xvalid & bit_zero;
`endif
endmodule

// File: tb/tb_seq_gen_tx.sv
// Scoreboard bench for seq_gen_tx: three instances covering GAP=1, GAP=2 and GAP=0.
module tb_seq_gen_tx;
`ifdef SEQ_GEN_TX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  // Packed observation: {ready, done, frame_end, xvalid, xout}
  localparam logic [4:0] IDLE_O = 5'b10000;

  logic clk, reset_n;
  int   n_tests = 0, n_fail = 0;
  int   fe_cnt, det, busy;
  logic [4:0] q[$];

  seq_gen_tx_if #(.PAT_W(3), .REP_W(4)) if0 ();
  seq_gen_tx_if #(.PAT_W(3), .REP_W(4)) if1 ();
  seq_gen_tx_if #(.PAT_W(8), .REP_W(4)) if2 ();

  seq_gen_tx #(.PAT_W(3), .REP_W(4), .GAP(1)) u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  seq_gen_tx #(.PAT_W(3), .REP_W(4), .GAP(2)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  seq_gen_tx #(.PAT_W(8), .REP_W(4), .GAP(0)) u2 (.clk(clk), .reset_n(reset_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pw_of(int sel);  return (sel == 2) ? 8 : 3; endfunction
  function automatic int gap_of(int sel); return (sel == 0) ? 1 : (sel == 1) ? 2 : 0; endfunction

  function automatic logic [4:0] obs(int sel);
    case (sel)
      0:       return {if0.ready, if0.done, if0.frame_end, if0.xvalid, if0.xout};
      1:       return {if1.ready, if1.done, if1.frame_end, if1.xvalid, if1.xout};
      default: return {if2.ready, if2.done, if2.frame_end, if2.xvalid, if2.xout};
    endcase
  endfunction

  task automatic drive(int sel, logic st, logic ab, logic [7:0] pat, logic [3:0] rep);
    case (sel)
      0: begin if0.start = st; if0.abort = ab; if0.pat_in = pat[2:0]; if0.rep_in = rep; end
      1: begin if1.start = st; if1.abort = ab; if1.pat_in = pat[2:0]; if1.rep_in = rep; end
      default: begin if2.start = st; if2.abort = ab; if2.pat_in = pat; if2.rep_in = rep; end
    endcase
  endtask

  task automatic check(string tag, logic [4:0] o, logic [4:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: rdy/done/fe/vld/x got %b expected %b", tag, o, e);
    end
  endtask

  task automatic check_int(string tag, int o, int e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, o, e);
    end
  endtask

  // Cycle-by-cycle expectation of one transfer, starting with the first bit cycle.
  task automatic push_frame(int sel, logic [7:0] pat, int rep);
    int pw = pw_of(sel);
    logic [7:0] m = 8'((1 << pw) - 1);
    for (int r = 0; r <= rep; r++) begin
      for (int b = pw - 1; b >= 0; b--)
        q.push_back({2'b00, (b == 0) && (PAR_EN == 0), 1'b1, pat[b]});
      if (PAR_EN != 0) q.push_back({3'b001, 1'b1, ^(pat & m)});
      if (r < rep) for (int g = 0; g < gap_of(sel); g++) q.push_back(5'b00000);
    end
    q.push_back(5'b11000);
  endtask

  task automatic run_frame(string tag, int sel, logic [7:0] pat, int rep,
                           bit b2b, int abort_at, bit hold);
    logic [4:0] o, e;
    logic [2:0] hist = 3'b000;
    int k = 0;
    fe_cnt = 0; det = 0; busy = 0;
    if (!b2b) @(negedge clk);
    drive(sel, 1'b1, 1'b0, pat, 4'(rep));
    push_frame(sel, pat, rep);
    @(posedge clk); #1;
    // A held start with a different pattern must not disturb the frame.
    if (hold) drive(sel, 1'b1, 1'b0, ~pat, 4'(rep));
    else      drive(sel, 1'b0, 1'b0, pat, 4'(rep));
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      o = obs(sel);
      check($sformatf("%s[%0d]", tag, k), o, e);
      fe_cnt += int'(o[2]);
      busy   += int'(!o[4]);
      if (o[1]) begin
        hist = {hist[1:0], o[0]};
        if (hist == 3'b101) det++;
      end
      k++;
      if (k == abort_at) begin
        drive(sel, 1'b0, 1'b1, pat, 4'(rep));
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, pat, 4'(rep));
        q.delete();
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 4'd0);
    drive(1, 1'b0, 1'b0, 8'h00, 4'd0);
    drive(2, 1'b0, 1'b0, 8'h00, 4'd0);
    #12;
    for (int s = 0; s < 3; s++) check($sformatf("reset%0d", s), obs(s), IDLE_O);
    @(negedge clk);
    reset_n = 1'b1;

    run_frame("p101_r0", 0, 8'h05, 0, 1'b0, 0, 1'b0);
    check_int("det101", det, 1);
    check_int("fe_r0", fe_cnt, 1);

    run_frame("p101_r2", 1, 8'h05, 2, 1'b0, 0, 1'b0);
    check_int("fe_r2", fe_cnt, 3);
    check_int("busy_r2", busy, 3 * (3 + PAR_EN) + 2 * 2);

    run_frame("pC3_r1", 2, 8'hC3, 1, 1'b0, 0, 1'b0);
    check_int("fe_c3", fe_cnt, 2);
    check_int("busy_c3", busy, 2 * (8 + PAR_EN));
    run_frame("b2b_5A", 2, 8'h5A, 0, 1'b1, 0, 1'b0);

    run_frame("abort", 2, 8'hC3, 2, 1'b0, 8 + PAR_EN + 5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort_idle%0d", i), obs(2), IDLE_O);
    end

    @(negedge clk);
    drive(2, 1'b1, 1'b1, 8'hFF, 4'd0);
    @(posedge clk); #1;
    drive(2, 1'b0, 1'b0, 8'hFF, 4'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("sa_idle%0d", i), obs(2), IDLE_O);
    end

    run_frame("par07", 2, 8'h07, 0, 1'b0, 0, 1'b0);
    run_frame("par03", 2, 8'h03, 0, 1'b0, 0, 1'b0);

    // Reset dropped between edges while bit 5 of 8'hA5 is on the line.
    @(negedge clk);
    drive(2, 1'b1, 1'b0, 8'hA5, 4'd0);
    @(posedge clk); #1;
    drive(2, 1'b0, 1'b0, 8'hA5, 4'd0);
    repeat (3) @(negedge clk);
    check("rst_pre", obs(2), 5'b00011);
    #2 reset_n = 1'b0;
    #1 check("rst_async", obs(2), IDLE_O);
    @(negedge clk);
    check("rst_hold", obs(2), IDLE_O);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_after%0d", i), obs(2), IDLE_O);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
